// File: rtl/sift_chk_pkg.sv
// Shared types and width helpers for the image-compare engine.
package sift_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Address width for a dimension; never below 1 so single-entry dimensions still get a legal port.
  function automatic int unsigned w_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Low bit of channel c inside the packed error-count vector.
  function automatic int unsigned ch_lo(input int unsigned c, input int unsigned w);
    return c * w;
  endfunction

endpackage

// File: rtl/blur_img_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, hold at all-ones, clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/blur_img_checker.sv
// Raster-scan compare of NUM_CH image planes (DUT vs golden) with tolerance,
// per-channel saturating mismatch counts and first-mismatch capture.
module blur_img_checker
  import sift_chk_pkg::*;
#(
  parameter int unsigned COLS   = 640,
  parameter int unsigned ROWS   = 480,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ERR_W  = 20,
  localparam int unsigned CH_W  = w_of(NUM_CH),
  localparam int unsigned ROW_W = w_of(ROWS),
  localparam int unsigned COL_W = w_of(COLS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [PIX_W-1:0]        tol,
  output logic                    rd_en,
  output logic [CH_W-1:0]         rd_ch,
  output logic [ROW_W-1:0]        rd_row,
  output logic [COL_W-1:0]        rd_col,
  input  logic [PIX_W-1:0]        dut_rdata,
  input  logic [PIX_W-1:0]        gold_rdata,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CH*ERR_W-1:0] err_cnt,
  output logic                    any_err,
  output logic                    first_err_vld,
  output logic [CH_W-1:0]         first_err_ch,
  output logic [ROW_W-1:0]        first_err_row,
  output logic [COL_W-1:0]        first_err_col,
  output logic [PIX_W-1:0]        first_err_dut,
  output logic [PIX_W-1:0]        first_err_gold
);

  state_t           state, next_state;
  logic             rd_en_d, clr_c, discard_c;
  logic             col_last_c, row_last_c, ch_last_c, last_c;
  logic [CH_W-1:0]  ch_d;
  logic [ROW_W-1:0] row_d;
  logic [COL_W-1:0] col_d;
  logic             cmp_vld;
  logic [CH_W-1:0]  cmp_ch;
  logic [ROW_W-1:0] cmp_row;
  logic [COL_W-1:0] cmp_col;
  logic [PIX_W:0]   diff_c;
  logic             mismatch_c;

  assign col_last_c = (rd_col == COL_W'(COLS - 1));
  assign row_last_c = (rd_row == ROW_W'(ROWS - 1));
  assign ch_last_c  = (rd_ch == CH_W'(NUM_CH - 1));
  assign last_c     = col_last_c && row_last_c && ch_last_c;
  assign discard_c  = abort && (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next state, next read strobe and next address (col fastest, then row, then ch).
  always_comb begin
    next_state = state;
    rd_en_d    = 1'b0;
    clr_c      = 1'b0;
    ch_d       = rd_ch;
    row_d      = rd_row;
    col_d      = rd_col;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          next_state = ST_SCAN;
          clr_c      = 1'b1;
          rd_en_d    = 1'b1;
          ch_d       = '0;
          row_d      = '0;
          col_d      = '0;
        end
      end
      ST_SCAN: begin
        if (abort) begin
          next_state = ST_IDLE;
        end else if (last_c) begin
          next_state = ST_DRAIN;
        end else begin
          rd_en_d = 1'b1;
          if (col_last_c) begin
            col_d = '0;
            if (row_last_c) begin
              row_d = '0;
              ch_d  = rd_ch + CH_W'(1);
            end else begin
              row_d = rd_row + ROW_W'(1);
            end
          end else begin
            col_d = rd_col + COL_W'(1);
          end
        end
      end
      ST_DRAIN: next_state = abort ? ST_IDLE : ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Registered read port and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en  <= 1'b0;
      rd_ch  <= '0;
      rd_row <= '0;
      rd_col <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      rd_en  <= rd_en_d;
      rd_ch  <= ch_d;
      rd_row <= row_d;
      rd_col <= col_d;
      busy   <= (next_state != ST_IDLE);
      done   <= (next_state == ST_DONE);
    end
  end

  // Align address with returning read data; an abort drops the read issued this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_vld <= 1'b0;
      cmp_ch  <= '0;
      cmp_row <= '0;
      cmp_col <= '0;
    end else begin
      cmp_vld <= rd_en && !discard_c;
      cmp_ch  <= rd_ch;
      cmp_row <= rd_row;
      cmp_col <= rd_col;
    end
  end

  // Absolute pixel difference and tolerance test.
  always_comb begin
    diff_c = '0;
    if (dut_rdata >= gold_rdata) diff_c = {1'b0, dut_rdata} - {1'b0, gold_rdata};
    else                         diff_c = {1'b0, gold_rdata} - {1'b0, dut_rdata};
  end

  assign mismatch_c = cmp_vld && (diff_c > {1'b0, tol});

  // Sticky error flag and first-mismatch capture, cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_err        <= 1'b0;
      first_err_vld  <= 1'b0;
      first_err_ch   <= '0;
      first_err_row  <= '0;
      first_err_col  <= '0;
      first_err_dut  <= '0;
      first_err_gold <= '0;
    end else if (clr_c) begin
      any_err        <= 1'b0;
      first_err_vld  <= 1'b0;
      first_err_ch   <= '0;
      first_err_row  <= '0;
      first_err_col  <= '0;
      first_err_dut  <= '0;
      first_err_gold <= '0;
    end else if (mismatch_c) begin
      any_err <= 1'b1;
      if (!first_err_vld) begin
        first_err_vld  <= 1'b1;
        first_err_ch   <= cmp_ch;
        first_err_row  <= cmp_row;
        first_err_col  <= cmp_col;
        first_err_dut  <= dut_rdata;
        first_err_gold <= gold_rdata;
      end
    end
  end

  // One saturating counter per channel.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
    localparam int unsigned LO = ch_lo(c, ERR_W);
    sat_counter #(.W(ERR_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_c),
      .inc   (mismatch_c && (cmp_ch == CH_W'(c))),
      .cnt   (err_cnt[LO +: ERR_W])
    );
  end

endmodule

// File: doc/blur_img_checker.md
Name: blur_img_checker

Overview:
- Synthesizable, parametrised image-compare engine; successor to the bench-side blurred-image golden comparison.
- Scans NUM_CH image planes (for example the four Gaussian blur layers) in raster order, reading each pixel from a DUT memory and a golden memory.
- Compares each pair against a programmable tolerance and keeps a saturating mismatch count per channel.
- Captures the first mismatch; used for on-chip self-check and as the bench scoreboard.

Parameters:
- COLS, 640, pixels per row
- ROWS, 480, rows per plane
- PIX_W, 8, pixel width in bits
- NUM_CH, 4, number of planes scanned
- ERR_W, 20, width of each per-channel error counter
- Derived widths: CH_W = max(1, clog2(NUM_CH)); ROW_W = clog2(ROWS); COL_W = clog2(COLS)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a scan when idle
- abort  in  1  synchronous scan cancel
- tol  in  PIX_W  allowed absolute difference; must be held stable while busy
- rd_en  out  1  read strobe to both memories
- rd_ch  out  CH_W  plane index
- rd_row  out  ROW_W  row address
- rd_col  out  COL_W  column address
- dut_rdata  in  PIX_W  DUT pixel, valid the cycle after rd_en
- gold_rdata  in  PIX_W  golden pixel, valid the cycle after rd_en
- busy  out  1  high from the cycle after start until done or abort
- done  out  1  one-cycle pulse; results final
- err_cnt  out  NUM_CH*ERR_W  per-channel counts, channel c at [c*ERR_W +: ERR_W]
- any_err  out  1  OR of all counters being nonzero
- first_err_vld  out  1  first mismatch has been captured
- first_err_ch / first_err_row / first_err_col  out  CH_W / ROW_W / COL_W  coordinates of the first mismatch
- first_err_dut / first_err_gold  out  PIX_W / PIX_W  pixel values of the first mismatch

Behaviour:
- Reset: every output and internal register is 0; FSM goes to IDLE.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - start=1 and abort=0: go to SCAN; clear all counters, first_err_*, and the address.
  - abort has priority over start.
- SCAN:
  - rd_en=1 every cycle.
  - Address advances col fastest, then row, then ch.
  - col wraps at COLS-1 to 0 and increments row; row wraps at ROWS-1 to 0 and increments ch.
  - After (NUM_CH-1, ROWS-1, COLS-1) is issued, go to DRAIN.
- DRAIN: rd_en=0 for one cycle while the last pair is compared; then go to DONE.
- DONE: done=1 for one cycle; then go to IDLE.
- Outputs rd_en and rd_* are registered. Let N = NUM_CH*ROWS*COLS, with start sampled at edge 0:
  - rd_en is high in cycles 1..N.
  - Compare data is valid in cycles 2..N+1.
  - done is high in cycle N+2.
- Compare pipeline:
  - rd_en and the address are delayed one stage to cmp_vld and cmp_addr.
  - diff = |dut - gold|, computed as an unsigned PIX_W+1 bit subtraction.
  - mismatch = cmp_vld & (diff > tol); tol=0 means exact match.
  - Counter and capture registers update at the edge ending the compare cycle.
- Counters:
  - err_cnt[ch] increments on each mismatch of that channel.
  - It saturates at 2^ERR_W-1 and never wraps.
- First-error capture:
  - Loaded only while first_err_vld=0; first_err_vld is set in the same update.
  - Held until the next accepted start.
- start while busy: ignored, with no effect on counters or address.
- abort while busy:
  - Next cycle the FSM is in IDLE, with rd_en=0, busy=0, and no done pulse.
  - An in-flight compare is discarded.
  - Partial counters and capture are kept.
- Reset mid-scan: immediate asynchronous clear of everything.
- Single-plane, single-row and single-column configurations must work; wrap logic must not assume dimensions ≥ 2.

Decomposition:
- Package sift_chk_pkg holds:
  - the FSM state enum (IDLE, SCAN, DRAIN, DONE);
  - a clog2-based width function, with CH_W clamped to ≥ 1;
  - the channel-slice helper constant for err_cnt.
- One natural sub-module, sat_counter:
  - parameter W; inputs clr and inc; output cnt; saturates at all-ones.
  - Instantiated NUM_CH times with a generate loop.

Test Plan (COLS=4, ROWS=3, NUM_CH=2, ERR_W=3, so N=24):
- Identical memories, tol=0, start at edge 0 -> rd_en in cycles 1..24, done pulse in cycle 26, err_cnt=0, any_err=0, first_err_vld=0.
- ch1/row2/col3 dut=10 gold=12, tol=0 -> err_cnt[1]=1, err_cnt[0]=0, first_err=(1,2,3,10,12); rerun with tol=2 -> all counts 0.
- Every pixel differs by 5, tol=4 -> both counters saturate at 7; first_err=(0,0,0); any_err=1.
- Address sequence check -> (0,0,0),(0,0,1)..(0,0,3),(0,1,0)..(0,2,3),(1,0,0)..(1,2,3).
- Abort asserted in cycle 10 -> rd_en=0 and busy=0 the next cycle, no done, counters hold their partial values.
- start asserted again at cycle 5 -> ignored, done still in cycle 26.
- rst_n low mid-scan -> all outputs 0 immediately; a fresh start completes normally.
